// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the priority event encoder family.
package prio_enc_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // One bit of the onehot(idx) decode: true when position pos is the decoded index.
  function automatic logic onehot_bit(input logic [31:0] idx, input logic [31:0] pos);
    return (idx == pos);
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational picker: rotate the request vector by base, search, then un-rotate the hit.
module prio_pick
  import prio_enc_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vec,
  input  logic [IDX_W-1:0] base,
  input  logic             mode,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  int         w_b;
  int         w_sel;
  logic [N-1:0] w_rot;

  // Fixed mode searches the unrotated vector for its highest bit; round-robin
  // searches upward from base, so the first hit after rotation wins.
  always_comb begin
    w_b   = (mode == MODE_RR) ? int'(base) : 0;
    w_rot = N'({vec, vec} >> w_b);
    w_sel = 0;
    found = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (w_rot[j]) begin
        if (mode == MODE_FIXED || !found) w_sel = j;
        found = 1'b1;
      end
    end
    idx = IDX_W'((w_sel + w_b) % N);
  end

endmodule

// File: rtl/prio_event_encoder.sv
// Sticky pending register feeding a valid/ready output slot; one event index per transfer.
module prio_event_encoder
  import prio_enc_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  input  logic             mode,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  input  logic             out_ready,
  output logic [N-1:0]     pending,
  output logic             any_pending
);

  logic [N-1:0]     r_pending;
  logic             r_out_valid;
  logic [IDX_W-1:0] r_out_idx;
  logic [IDX_W-1:0] r_last;

  logic [N-1:0]     w_oh;
  logic [N-1:0]     w_clr;
  logic [N-1:0]     w_cand;
  logic             w_xfer;
  logic             w_reload;
  logic [IDX_W-1:0] w_last_eff;
  logic [IDX_W-1:0] w_base;
  logic             w_found;
  logic [IDX_W-1:0] w_pick_idx;

  for (genvar gi = 0; gi < N; gi++) begin : g_oh
    assign w_oh[gi] = onehot_bit(32'(r_out_idx), 32'(gi));
  end

  assign w_xfer   = r_out_valid & out_ready;
  assign w_reload = ~r_out_valid | w_xfer;
  assign w_clr    = w_xfer ? w_oh : '0;
  assign w_cand   = r_pending & mask & ~w_clr;

  // The index leaving on this edge already counts as the last one served,
  // so back-to-back round-robin transfers advance without a bubble.
  assign w_last_eff = w_xfer ? r_out_idx : r_last;
  assign w_base     = (w_last_eff == IDX_W'(N - 1)) ? '0 : w_last_eff + IDX_W'(1);

  prio_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .vec   (w_cand),
    .base  (w_base),
    .mode  (mode),
    .found (w_found),
    .idx   (w_pick_idx)
  );

  // Pending capture and output slot update
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending   <= '0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_last      <= IDX_W'(N - 1);
    end else begin
      r_pending <= (r_pending & ~w_clr) | req;
      if (w_xfer) r_last <= r_out_idx;
      if (w_reload) begin
        r_out_valid <= w_found;
        if (w_found) r_out_idx <= w_pick_idx;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_idx     = r_out_idx;
  assign pending     = r_pending;
  assign any_pending = |(r_pending & mask);

endmodule

// File: tb/tb_prio_event_encoder.sv
// Directed bench for prio_event_encoder: an N=8 instance plus an N=6 instance for wrap behaviour.
module tb_prio_event_encoder;

  logic       clk;
  logic       rst;
  logic [7:0] req, mask;
  logic       mode, out_ready, out_valid, any_pending;
  logic [2:0] out_idx;
  logic [7:0] pending;

  logic [5:0] req6, mask6, pending6;
  logic       mode6, out_ready6, out_valid6, any_pending6;
  logic [2:0] out_idx6;

  int n_checks = 0;
  int n_fails  = 0;

  prio_event_encoder #(.N(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .mask        (mask),
    .mode        (mode),
    .out_valid   (out_valid),
    .out_idx     (out_idx),
    .out_ready   (out_ready),
    .pending     (pending),
    .any_pending (any_pending)
  );

  prio_event_encoder #(.N(6)) dut6 (
    .clk         (clk),
    .rst         (rst),
    .req         (req6),
    .mask        (mask6),
    .mode        (mode6),
    .out_valid   (out_valid6),
    .out_idx     (out_idx6),
    .out_ready   (out_ready6),
    .pending     (pending6),
    .any_pending (any_pending6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; mask = 8'hFF; mode = 1'b0; out_ready = 1'b0;
    req6 = '0; mask6 = 6'h3F; mode6 = 1'b1; out_ready6 = 1'b1;

    // 1: reset and idle
    do_reset();
    check("rst_valid",   32'(out_valid),   32'd0);
    check("rst_idx",     32'(out_idx),     32'd0);
    check("rst_pending", 32'(pending),     32'd0);
    check("rst_any",     32'(any_pending), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    check("idle_valid",   32'(out_valid),   32'd0);
    check("idle_pending", 32'(pending),     32'd0);
    check("idle_any",     32'(any_pending), 32'd0);

    // 2: fixed priority, single pulse 1010_0100
    mode = 1'b0; out_ready = 1'b1; req = 8'hA4;
    tick();
    req = 8'h00;
    check("fx_pend_set", 32'(pending),   32'hA4);
    check("fx_lat_v0",   32'(out_valid), 32'd0);
    tick();
    check("fx_v7",   32'(out_valid), 32'd1);
    check("fx_i7",   32'(out_idx),   32'd7);
    tick();
    check("fx_i5",   32'(out_idx),   32'd5);
    check("fx_p5",   32'(pending),   32'h24);
    tick();
    check("fx_i2",   32'(out_idx),   32'd2);
    check("fx_v2",   32'(out_valid), 32'd1);
    tick();
    check("fx_vend", 32'(out_valid), 32'd0);
    check("fx_pend", 32'(pending),   32'h00);

    // 3: round-robin, all lines once
    do_reset();
    mode = 1'b1; out_ready = 1'b1; req = 8'hFF;
    tick();
    req = 8'h00;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("rr_idx%0d", k), 32'(out_idx), 32'(k));
      check($sformatf("rr_v%0d", k), 32'(out_valid), 32'd1);
    end
    tick();
    check("rr_vend", 32'(out_valid), 32'd0);

    // 4: hold while not ready, then fixed presents 6
    do_reset();
    mode = 1'b0; out_ready = 1'b0; req = 8'h08;
    tick();
    req = 8'h00;
    tick();
    check("hd_i3", 32'(out_idx), 32'd3);
    req = 8'h40;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) mask = 8'h00;
      if (c == 3) mode = 1'b1;
      tick();
      req = 8'h00;
      check($sformatf("hd_hold_i%0d", c), 32'(out_idx), 32'd3);
      check($sformatf("hd_hold_v%0d", c), 32'(out_valid), 32'd1);
    end
    check("hd_pend", 32'(pending), 32'h48);
    mask = 8'hFF; mode = 1'b0; out_ready = 1'b1;
    tick();
    check("hd_i6", 32'(out_idx),   32'd6);
    check("hd_v6", 32'(out_valid), 32'd1);
    tick();
    check("hd_vend", 32'(out_valid), 32'd0);

    // 5: re-request on the transfer edge
    do_reset();
    mode = 1'b0; out_ready = 1'b0; req = 8'h11;
    tick();
    req = 8'h00;
    tick();
    check("rp_i4", 32'(out_idx), 32'd4);
    out_ready = 1'b1; req = 8'h10;
    tick();
    req = 8'h00;
    check("rp_pend4", 32'(pending[4]), 32'd1);
    check("rp_i0",    32'(out_idx),    32'd0);
    tick();
    check("rp_i4b",   32'(out_idx),    32'd4);
    check("rp_v4b",   32'(out_valid),  32'd1);
    tick();
    check("rp_vend",  32'(out_valid),  32'd0);
    check("rp_pend",  32'(pending),    32'h00);

    // 6: mask gating and reset mid-stream
    do_reset();
    mode = 1'b0; out_ready = 1'b0; mask = 8'h0F; req = 8'hF0;
    tick();
    req = 8'h00;
    tick();
    check("mk_v0",   32'(out_valid),   32'd0);
    check("mk_pend", 32'(pending),     32'hF0);
    check("mk_any0", 32'(any_pending), 32'd0);
    mask = 8'hFF;
    tick();
    check("mk_i7",   32'(out_idx),     32'd7);
    check("mk_v1",   32'(out_valid),   32'd1);
    check("mk_any1", 32'(any_pending), 32'd1);
    rst = 1'b1; req = 8'hFF;
    tick();
    check("mr_valid", 32'(out_valid),   32'd0);
    check("mr_idx",   32'(out_idx),     32'd0);
    check("mr_pend",  32'(pending),     32'h00);
    check("mr_any",   32'(any_pending), 32'd0);
    rst = 1'b0; req = 8'h00;
    tick();
    check("mr_after_pend",  32'(pending),   32'h00);
    check("mr_after_valid", 32'(out_valid), 32'd0);

    // 7: N=6 round-robin wrap
    do_reset();
    req6 = 6'h3F;
    tick();
    req6 = 6'h00;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("n6_idx%0d", k), 32'(out_idx6), 32'(k));
    end
    tick();
    check("n6_vend", 32'(out_valid6), 32'd0);
    req6 = 6'h21;
    tick();
    req6 = 6'h00;
    tick();
    check("n6_wrap0", 32'(out_idx6),   32'd0);
    check("n6_wrapv", 32'(out_valid6), 32'd1);
    tick();
    check("n6_wrap5", 32'(out_idx6),   32'd5);
    tick();
    check("n6_vend2", 32'(out_valid6), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
